// File: rtl/cla_chunk_sequencer_if.sv
// ---------------------------------------------------------------------------
// cla_chunk_sequencer_if
// Handshake bundle for the chunked carry-lookahead add/sub sequencer.
//   Request side : io_in_valid/io_in_ready, operands io_in_a/io_in_b,
//                  io_in_cin (add carry-in), io_in_sub (1 = A - B).
//   Result side  : io_out_valid/io_out_ready, io_out_sum, io_out_cout,
//                  io_out_ovf (signed overflow), io_busy (BUSY or DONE).
// Modports: master = issuing stage / consumer, slave = the sequencer.
// ---------------------------------------------------------------------------
interface cla_chunk_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             io_in_valid;
    logic             io_in_ready;
    logic [WIDTH-1:0] io_in_a;
    logic [WIDTH-1:0] io_in_b;
    logic             io_in_cin;
    logic             io_in_sub;
    logic             io_out_valid;
    logic             io_out_ready;
    logic [WIDTH-1:0] io_out_sum;
    logic             io_out_cout;
    logic             io_out_ovf;
    logic             io_busy;

    modport master (
        output io_in_valid, io_in_a, io_in_b, io_in_cin, io_in_sub, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_sum, io_out_cout, io_out_ovf, io_busy
    );

    modport slave (
        input  io_in_valid, io_in_a, io_in_b, io_in_cin, io_in_sub, io_out_ready,
        output io_in_ready, io_out_valid, io_out_sum, io_out_cout, io_out_ovf, io_busy
    );
endinterface

// File: rtl/cla_chunk_sequencer.sv
// ---------------------------------------------------------------------------
// cla_chunk_sequencer
// Multi-cycle WIDTH-bit adder/subtractor. One CHUNK-bit carry-lookahead slice
// is reused over NBEATS = WIDTH/CHUNK beats, LSB chunk first, with the
// inter-chunk carry held in a 1-bit register.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous active-high reset (also masks io_in_ready)
//   bus   - cla_chunk_sequencer_if.slave request/result handshake bundle
// Latency: accept at edge T, io_out_valid high after edge T+NBEATS.
// ---------------------------------------------------------------------------
module cla_chunk_sequencer #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    cla_chunk_sequencer_if.slave    bus
);

    localparam int NBEATS = WIDTH / CHUNK;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [CHUNK-1:0] sum;
        logic             cout;
        logic             gg;   // group generate (carry-in independent)
        logic             gp;   // group propagate
    } slice_t;

    // Carry-lookahead slice: every carry is formed directly from the bit
    // generate/propagate terms and the slice carry-in, no ripple chain.
    function automatic slice_t cla_slice(
        input logic [CHUNK-1:0] a,
        input logic [CHUNK-1:0] b,
        input logic             cin
    );
        logic [CHUNK-1:0] g;
        logic [CHUNK-1:0] p;
        logic [CHUNK:0]   c;
        logic             acc;
        logic             pp;
        slice_t           r;
        g    = a & b;
        p    = a ^ b;
        c    = {(CHUNK+1){1'b0}};
        c[0] = cin;
        acc  = 1'b0;
        pp   = 1'b1;
        for (int i = 0; i < CHUNK; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            c[i+1] = acc | (pp & cin);
        end
        // After the last iteration acc/pp span the whole slice.
        r.gg   = acc;
        r.gp   = pp;
        r.sum  = p ^ c[CHUNK-1:0];
        r.cout = c[CHUNK];
        return r;
    endfunction

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;        // already inverted for subtraction
    logic             r_carry;
    logic [BW-1:0]    r_beat;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_in_ready;

    logic [CHUNK-1:0] w_slice_a;
    logic [CHUNK-1:0] w_slice_b;
    slice_t           w_slice;
    logic             w_last_beat;

    // Select the current chunk of the latched operands and evaluate the slice.
    always_comb begin
        w_slice_a   = r_a[r_beat*CHUNK +: CHUNK];
        w_slice_b   = r_b[r_beat*CHUNK +: CHUNK];
        w_slice     = cla_slice(w_slice_a, w_slice_b, r_carry);
        w_last_beat = (r_beat == BW'(NBEATS - 1));
    end

    // Control FSM with operand, carry, beat and result registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_a         <= {WIDTH{1'b0}};
            r_b         <= {WIDTH{1'b0}};
            r_carry     <= 1'b0;
            r_beat      <= {BW{1'b0}};
            r_sum       <= {WIDTH{1'b0}};
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;   // masked by reset at the output
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.io_in_valid) begin
                        r_a        <= bus.io_in_a;
                        r_b        <= bus.io_in_sub ? ~bus.io_in_b : bus.io_in_b;
                        r_carry    <= bus.io_in_sub ? 1'b1 : bus.io_in_cin;
                        r_beat     <= {BW{1'b0}};
                        r_state    <= S_BUSY;
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    r_sum[r_beat*CHUNK +: CHUNK] <= w_slice.sum;
                    r_carry <= w_slice.gg | (w_slice.gp & r_carry);
                    if (w_last_beat) begin
                        r_beat      <= {BW{1'b0}};
                        r_cout      <= w_slice.cout;
                        r_ovf       <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                       (w_slice.sum[CHUNK-1] != r_a[WIDTH-1]);
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_beat <= r_beat + BW'(1);
                    end
                end
                S_DONE: begin
                    // New requests are ignored here; only the consumer moves us on.
                    if (bus.io_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    // Reset gates io_in_ready combinationally so it drops the moment reset rises.
    assign bus.io_in_ready  = r_in_ready & ~reset;
    assign bus.io_out_valid = r_out_valid;
    assign bus.io_out_sum   = r_sum;
    assign bus.io_out_cout  = r_cout;
    assign bus.io_out_ovf   = r_ovf;
    assign bus.io_busy      = r_busy;

endmodule

// File: tb/tb_cla_chunk_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cla_chunk_sequencer
// Directed bench for cla_chunk_sequencer (WIDTH=32, CHUNK=8): a table of
// hand-computed operations plus sequences for backpressure, reset during
// BUSY and back-to-back issue.
// ---------------------------------------------------------------------------
module tb_cla_chunk_sequencer;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_fail;

    cla_chunk_sequencer_if #(.WIDTH(32)) bus_if ();

    cla_chunk_sequencer #(.WIDTH(32), .CHUNK(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs [5];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub, output time t_acc);
        chk("in_ready_before_accept", {31'd0, bus_if.io_in_ready}, 32'd1);
        bus_if.io_in_a     = a;
        bus_if.io_in_b     = b;
        bus_if.io_in_cin   = cin;
        bus_if.io_in_sub   = sub;
        bus_if.io_in_valid = 1'b1;
        @(posedge clock);
        t_acc = $time;
        #1;
        bus_if.io_in_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, input logic [31:0] e_sum,
                               input logic e_cout, input logic e_ovf, input bit release_out);
        int cyc;
        bit rdy_seen;
        cyc      = 0;
        rdy_seen = 1'b0;
        while (!bus_if.io_out_valid && cyc < 20) begin
            if (bus_if.io_in_ready) rdy_seen = 1'b1;
            @(posedge clock);
            #1;
            cyc++;
        end
        chk({name, "_latency"}, 32'(cyc), 32'd4);
        chk({name, "_ready_low"}, {31'd0, rdy_seen | bus_if.io_in_ready}, 32'd0);
        chk({name, "_busy"}, {31'd0, bus_if.io_busy}, 32'd1);
        chk({name, "_sum"}, bus_if.io_out_sum, e_sum);
        chk({name, "_cout"}, {31'd0, bus_if.io_out_cout}, {31'd0, e_cout});
        chk({name, "_ovf"}, {31'd0, bus_if.io_out_ovf}, {31'd0, e_ovf});
        if (release_out) begin
            bus_if.io_out_ready = 1'b1;
            @(posedge clock);
            #1;
            bus_if.io_out_ready = 1'b0;
        end
    endtask

    initial begin
        time t0;
        time t1;
        bit  bad_valid;
        bit  bad_data;
        bit  bad_ready;
        n_cmp  = 0;
        n_fail = 0;

        vecs[0] = '{a: 32'h000000FF, b: 32'h00000001, cin: 1'b0, sub: 1'b0,
                    sum: 32'h00000100, cout: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 32'hFFFFFFFF, b: 32'h00000001, cin: 1'b0, sub: 1'b0,
                    sum: 32'h00000000, cout: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 32'h00000005, b: 32'h00000006, cin: 1'b1, sub: 1'b0,
                    sum: 32'h0000000C, cout: 1'b0, ovf: 1'b0};
        vecs[3] = '{a: 32'h7FFFFFFF, b: 32'h00000001, cin: 1'b0, sub: 1'b0,
                    sum: 32'h80000000, cout: 1'b0, ovf: 1'b1};
        vecs[4] = '{a: 32'h80000000, b: 32'h00000001, cin: 1'b1, sub: 1'b1,
                    sum: 32'h7FFFFFFF, cout: 1'b1, ovf: 1'b1};

        reset               = 1'b1;
        bus_if.io_in_valid  = 1'b0;
        bus_if.io_in_a      = 32'd0;
        bus_if.io_in_b      = 32'd0;
        bus_if.io_in_cin    = 1'b0;
        bus_if.io_in_sub    = 1'b0;
        bus_if.io_out_ready = 1'b0;

        // Reset values while reset is held.
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_in_ready", {31'd0, bus_if.io_in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, bus_if.io_out_valid}, 32'd0);
        chk("rst_sum", bus_if.io_out_sum, 32'd0);
        chk("rst_cout", {31'd0, bus_if.io_out_cout}, 32'd0);
        chk("rst_ovf", {31'd0, bus_if.io_out_ovf}, 32'd0);
        chk("rst_busy", {31'd0, bus_if.io_busy}, 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, bus_if.io_in_ready}, 32'd1);

        // Table-driven operations, each released after its result.
        for (int i = 0; i < 5; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, t0);
            wait_result($sformatf("vec%0d", i), vecs[i].sum, vecs[i].cout, vecs[i].ovf, 1'b1);
        end

        // Reset during beat 2; upper chunks still hold 0x7FFF from the last result.
        issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, t0);
        @(posedge clock);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, bus_if.io_busy}, 32'd0);
        chk("midrst_out_valid", {31'd0, bus_if.io_out_valid}, 32'd0);
        chk("midrst_sum", bus_if.io_out_sum, 32'd0);
        chk("midrst_in_ready", {31'd0, bus_if.io_in_ready}, 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("midrst_release_ready", {31'd0, bus_if.io_in_ready}, 32'd1);
        issue(32'h00000003, 32'h00000004, 1'b0, 1'b0, t0);
        wait_result("after_rst", 32'h00000007, 1'b0, 1'b0, 1'b1);

        // Backpressure: result held 10 cycles, concurrent request not taken.
        issue(32'h000000FF, 32'h00000001, 1'b0, 1'b0, t0);
        wait_result("bp", 32'h00000100, 1'b0, 1'b0, 1'b0);
        bus_if.io_in_a     = 32'h00000001;
        bus_if.io_in_b     = 32'h00000001;
        bus_if.io_in_cin   = 1'b0;
        bus_if.io_in_sub   = 1'b0;
        bus_if.io_in_valid = 1'b1;
        bad_valid = 1'b0;
        bad_data  = 1'b0;
        bad_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clock);
            #1;
            if (bus_if.io_out_valid !== 1'b1) bad_valid = 1'b1;
            if (bus_if.io_out_sum !== 32'h00000100 || bus_if.io_out_cout !== 1'b0 ||
                bus_if.io_out_ovf !== 1'b0) bad_data = 1'b1;
            if (bus_if.io_in_ready !== 1'b0) bad_ready = 1'b1;
        end
        chk("bp_valid_held", {31'd0, bad_valid}, 32'd0);
        chk("bp_data_stable", {31'd0, bad_data}, 32'd0);
        chk("bp_ready_low", {31'd0, bad_ready}, 32'd0);
        bus_if.io_out_ready = 1'b1;
        @(posedge clock);
        #1;
        bus_if.io_out_ready = 1'b0;
        chk("bp_release_valid", {31'd0, bus_if.io_out_valid}, 32'd0);
        chk("bp_release_ready", {31'd0, bus_if.io_in_ready}, 32'd1);
        @(posedge clock);
        #1;
        bus_if.io_in_valid = 1'b0;
        wait_result("bp_next", 32'h00000002, 1'b0, 1'b0, 1'b1);

        // Back-to-back with io_out_ready tied high: 6-cycle issue interval.
        bus_if.io_out_ready = 1'b1;
        issue(32'h12345678, 32'h11111111, 1'b0, 1'b0, t0);
        wait_result("b2b0", 32'h23456789, 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        issue(32'h00000010, 32'h00000020, 1'b0, 1'b1, t1);
        wait_result("b2b1", 32'hFFFFFFF0, 1'b0, 1'b0, 1'b0);
        chk("b2b_interval", 32'((t1 - t0) / 64'd10), 32'd6);
        @(posedge clock);
        #1;
        bus_if.io_out_ready = 1'b0;
        chk("b2b_final_idle", {31'd0, bus_if.io_busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cla_chunk_sequencer.md
# cla_chunk_sequencer

Multi-cycle wide adder/subtractor controller. It accepts WIDTH-bit operand pairs through a valid/ready handshake and sequences a single CHUNK-bit carry-lookahead adder slice over WIDTH/CHUNK beats, LSB chunk first. Between beats it holds the inter-chunk carry in a register, and it presents the full result, carry-out and signed overflow through a second valid/ready handshake. It sits between an issuing pipeline stage and a consumer, trading latency for adder area.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be a positive multiple of CHUNK.
- CHUNK, 8, width of the CLA slice reused each beat; NBEATS = WIDTH/CHUNK.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- io_in_valid  in  1  operation request.
- io_in_ready  out  1  block can accept; high only in IDLE and reset low.
- io_in_a  in  WIDTH  operand A.
- io_in_b  in  WIDTH  operand B.
- io_in_cin  in  1  carry-in for add; ignored when io_in_sub=1.
- io_in_sub  in  1  1 = A - B (A + ~B + 1), 0 = A + B + cin.
- io_out_valid  out  1  result available.
- io_out_ready  in  1  consumer takes result.
- io_out_sum  out  WIDTH  result.
- io_out_cout  out  1  carry out of MSB (for sub: 1 = no borrow).
- io_out_ovf  out  1  two's-complement overflow.
- io_busy  out  1  high in BUSY or DONE.

## Operation
- States: IDLE, BUSY, DONE. Reset → IDLE, beat counter 0, carry register 0, sum/cout/ovf registers 0.
- IDLE: io_in_ready=1. When io_in_valid and io_in_ready are both high at a clock edge:
  - latch A;
  - latch B' = io_in_sub ? ~B : B;
  - carry = io_in_sub ? 1 : io_in_cin;
  - beat = 0;
  - go BUSY.
- BUSY, each cycle:
  - slice inputs A[beat*CHUNK +: CHUNK], B'[same], carry-in = carry register;
  - sum register chunk[beat] ← slice sum;
  - carry ← slice group generate | (group propagate & carry);
  - beat ← beat+1.
- On beat NBEATS-1:
  - cout ← slice carry-out;
  - ovf ← (A[MSB] == B'[MSB]) && (slice sum MSB != A[MSB]);
  - go DONE.
- DONE: io_out_valid=1. Sum, cout and ovf are held stable. On io_out_ready → IDLE. io_in_valid is ignored in DONE.
- Width rules:
  - all arithmetic is modulo 2^WIDTH;
  - carry-out of the final chunk goes only to io_out_cout;
  - the carry register is exactly 1 bit.
- io_out_sum is valid only while io_out_valid=1. Intermediate chunks are visible during BUSY but are not meaningful. After the handshake, the last result remains on the outputs until the next BUSY overwrites chunk 0.
- Reset mid-operation (BUSY or DONE): asynchronous return to IDLE; all output registers 0; the in-flight operation is discarded with no output handshake.
- io_in_ready is forced 0 while reset is high.

## Timing
- Output reset values:
  - io_in_ready 0 while reset is asserted, 1 in the first cycle after deassertion;
  - io_out_valid 0, io_out_sum 0, io_out_cout 0, io_out_ovf 0, io_busy 0.
- Latency: accept at edge T → io_out_valid high after edge T+NBEATS (defaults: 4 cycles).
- io_in_ready falls after edge T and stays low until the edge after the output handshake.
- Minimum issue interval: NBEATS+2 cycles (accept edge, NBEATS BUSY beats, DONE handshake, IDLE). This assumes io_out_ready is held high.
- io_out_valid, once asserted, stays high until the handshake edge; the data does not change while valid.
- No combinational path from io_in_* to io_out_*. The only combinational path from an input to an output is reset → io_in_ready.

## Test plan
All scenarios use WIDTH=32 and CHUNK=8.
- Add, no ripple: A=0x000000FF, B=0x00000001, cin=0, sub=0 → sum 0x00000100, cout 0, ovf 0. io_out_valid rises exactly 4 cycles after the accept edge; io_in_ready is low for those cycles.
- Full carry ripple across all beats: A=0xFFFFFFFF, B=0x00000001, cin=0 → sum 0x00000000, cout 1, ovf 0. Also A=0x00000005, B=0x00000006, cin=1 → 0x0000000C.
- Signed overflow:
  - add A=0x7FFFFFFF, B=1 → sum 0x80000000, cout 0, ovf 1;
  - sub A=0x80000000, B=1, cin=1 (ignored) → sum 0x7FFFFFFF, cout 1, ovf 1.
- Backpressure: hold io_out_ready=0 for 10 cycles after io_out_valid rises → io_out_valid, sum, cout and ovf stay stable; io_in_ready stays 0; a concurrent io_in_valid with A=1, B=1 is not accepted. After io_out_ready=1 for one cycle, that request is accepted in IDLE and yields sum 2.
- Reset mid-BUSY: assert reset during beat 2 of A=0xFFFFFFFF + B=1 → immediately io_busy=0, io_out_valid=0, io_out_sum=0. After release, A=3, B=4 yields sum 7 with correct 4-cycle latency and no stale carry.
- Back-to-back operations with io_out_ready tied high: 0x12345678 + 0x11111111 then sub 0x10 - 0x20 → 0x23456789 (cout 0), then 0xFFFFFFF0 (cout 0, ovf 0). The issue interval is exactly 6 cycles.
